// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the byte-wide RAM port controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    MC_IDLE   = 3'd0,
    MC_IF_RD  = 3'd1,
    MC_MEM_RD = 3'd2,
    MC_MEM_WR = 3'd3,
    MC_DONE   = 3'd4
  } mc_state_t;

  localparam logic [1:0] LenByte = 2'd0;
  localparam logic [1:0] LenHalf = 2'd1;
  localparam logic [1:0] LenWord = 2'd2;

  // addr[17:16] value that selects the IO region
  localparam logic [1:0] IO_ADDR_HI = 2'b11;

  localparam logic True_v  = 1'b1;
  localparam logic False_v = 1'b0;

  // Byte count for a MEM access; code 3 is treated as a word.
  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      LenByte: return 3'd1;
      LenHalf: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_pack.sv
// Byte lane select/insert on a little-endian 32-bit word.
// Latency: combinational.
// Backpressure: none.
// Ports: idx - byte lane; word_in - source word; byte_in - byte to insert;
//        byte_out - lane idx of word_in; word_out - word_in with lane idx = byte_in.
module mem_byte_pack (
  input  logic [1:0]  idx,
  input  logic [31:0] word_in,
  input  logic [7:0]  byte_in,
  output logic [7:0]  byte_out,
  output logic [31:0] word_out
);

  always_comb begin
    byte_out = word_in[{idx, 3'b000} +: 8];
    word_out = word_in;
    word_out[{idx, 3'b000} +: 8] = byte_in;
  end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates IF fetches and MEM loads/stores onto one byte-wide RAM port.
// Latency: read done at C1+n+1, write done at C1+n (C1 = first cycle after accept).
// Backpressure: requesters hold req until their done pulse; MEM wins ties; IF flushable.
// Ports: clk_in/rst_in (sync, active high); if_* fetch requester; mem_* load/store
//        requester; flush_in aborts a fetch; busy_out = not idle; ram_* byte RAM port.
// Optional: define MEM_CTRL_IO_GUARD_EN to add io_buffer_full_in, which stalls
//        stores to the IO region (addr[17:16] == IO_ADDR_HI) while it is high.
module mem_ctrl #(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [1:0] IO_ADDR_HI = mem_ctrl_pkg::IO_ADDR_HI
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  if_req_in,
  input  logic [ADDR_WIDTH-1:0] if_addr_in,
  output logic                  if_done_out,
  output logic [31:0]           if_inst_out,
  input  logic                  mem_req_in,
  input  logic                  mem_we_in,
  input  logic [1:0]            mem_len_in,
  input  logic [ADDR_WIDTH-1:0] mem_addr_in,
  input  logic [31:0]           mem_wdata_in,
  output logic                  mem_done_out,
  output logic [31:0]           mem_rdata_out,
  input  logic                  flush_in,
  output logic                  busy_out,
  output logic [ADDR_WIDTH-1:0] ram_a_out,
  output logic                  ram_wr_out,
  output logic [7:0]            ram_dout_out,
  input  logic [7:0]            ram_din_in
`ifdef MEM_CTRL_IO_GUARD_EN
  ,
  input  logic                  io_buffer_full_in
`endif
);

  import mem_ctrl_pkg::*;

  mc_state_t             state_q, state_d;
  logic [2:0]            acnt_q, acnt_d;     // index of the byte address on ram_a_out
  logic [2:0]            n_q, n_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           asm_q, asm_d;

  logic [ADDR_WIDTH-1:0] ram_a_d;
  logic                  ram_wr_d;
  logic [7:0]            ram_dout_d;
  logic                  if_done_d, mem_done_d, busy_d;
  logic [31:0]           if_inst_d, mem_rdata_d;

  logic io_full;
`ifdef MEM_CTRL_IO_GUARD_EN
  assign io_full = io_buffer_full_in;
`else
  assign io_full = 1'b0;
`endif

  logic [2:0]            next_idx, issue_idx;
  logic [1:0]            rd_idx;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic                  issue_blk, accept_blk, rd_last, wr_last;

  assign next_idx   = acnt_q + 3'd1;
  // A write byte is retried in place until it actually goes out with ram_wr high.
  assign issue_idx  = ram_wr_out ? next_idx : acnt_q;
  assign issue_addr = base_q + ADDR_WIDTH'(issue_idx);
  assign issue_blk  = io_full && (issue_addr[17:16] == IO_ADDR_HI);
  assign accept_blk = io_full && (mem_addr_in[17:16] == IO_ADDR_HI);
  // Read data lags its address by one cycle, so the lane being captured is acnt-1.
  assign rd_idx     = acnt_q[1:0] - 2'd1;
  assign rd_last    = (acnt_q == n_q);
  assign wr_last    = ram_wr_out && (next_idx == n_q);

  logic [1:0]  pack_idx;
  logic [31:0] pack_word_in, pack_word_out;
  logic [7:0]  pack_byte_out;

  assign pack_idx     = (state_q == MC_MEM_WR) ? issue_idx[1:0] : rd_idx;
  assign pack_word_in = (state_q == MC_MEM_WR) ? wdata_q : asm_q;

  mem_byte_pack u_pack (
    .idx      (pack_idx),
    .word_in  (pack_word_in),
    .byte_in  (ram_din_in),
    .byte_out (pack_byte_out),
    .word_out (pack_word_out)
  );

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= MC_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      MC_IDLE: begin
        if (mem_req_in)                   state_d = mem_we_in ? MC_MEM_WR : MC_MEM_RD;
        else if (if_req_in && !flush_in)  state_d = MC_IF_RD;
      end
      MC_IF_RD: begin
        if (flush_in)     state_d = MC_IDLE;
        else if (rd_last) state_d = MC_DONE;
      end
      MC_MEM_RD: if (rd_last) state_d = MC_DONE;
      MC_MEM_WR: if (wr_last) state_d = MC_DONE;
      MC_DONE:   state_d = MC_IDLE;
      default:   state_d = MC_IDLE;
    endcase
  end

  // Output / datapath next values; everything is registered below.
  always_comb begin
    acnt_d      = acnt_q;
    n_d         = n_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    ram_a_d     = '0;
    ram_wr_d    = False_v;
    ram_dout_d  = 8'h00;
    if_done_d   = False_v;
    mem_done_d  = False_v;
    if_inst_d   = if_inst_out;
    mem_rdata_d = mem_rdata_out;

    case (state_q)
      MC_IDLE: begin
        if (mem_req_in) begin
          base_d  = mem_addr_in;
          n_d     = len_to_n(mem_len_in);
          wdata_d = mem_wdata_in;
          asm_d   = 32'h0;
          acnt_d  = 3'd0;
          ram_a_d = mem_addr_in;
          if (mem_we_in && !accept_blk) begin
            ram_wr_d   = True_v;
            ram_dout_d = mem_wdata_in[7:0];
          end
        end else if (if_req_in && !flush_in) begin
          base_d  = if_addr_in;
          n_d     = 3'd4;
          asm_d   = 32'h0;
          acnt_d  = 3'd0;
          ram_a_d = if_addr_in;
        end
      end

      MC_IF_RD, MC_MEM_RD: begin
        if (state_q == MC_IF_RD && flush_in) begin
          acnt_d = 3'd0;
        end else begin
          if (acnt_q != 3'd0) asm_d = pack_word_out;
          if (rd_last) begin
            acnt_d = 3'd0;
            if (state_q == MC_IF_RD) begin
              if_done_d = True_v;
              if_inst_d = pack_word_out;
            end else begin
              mem_done_d  = True_v;
              mem_rdata_d = pack_word_out;
            end
          end else begin
            acnt_d = next_idx;
            if (next_idx < n_q) ram_a_d = base_q + ADDR_WIDTH'(next_idx);
          end
        end
      end

      MC_MEM_WR: begin
        if (wr_last) begin
          mem_done_d = True_v;
          acnt_d     = 3'd0;
        end else begin
          acnt_d     = issue_idx;
          ram_a_d    = issue_addr;
          ram_wr_d   = !issue_blk;
          ram_dout_d = issue_blk ? 8'h00 : pack_byte_out;
        end
      end

      default: ;
    endcase

    busy_d = (state_d != MC_IDLE) ? True_v : False_v;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acnt_q        <= 3'd0;
      n_q           <= 3'd0;
      base_q        <= '0;
      wdata_q       <= 32'h0;
      asm_q         <= 32'h0;
      ram_a_out     <= '0;
      ram_wr_out    <= 1'b0;
      ram_dout_out  <= 8'h00;
      if_done_out   <= 1'b0;
      mem_done_out  <= 1'b0;
      if_inst_out   <= 32'h0;
      mem_rdata_out <= 32'h0;
      busy_out      <= 1'b0;
    end else begin
      acnt_q        <= acnt_d;
      n_q           <= n_d;
      base_q        <= base_d;
      wdata_q       <= wdata_d;
      asm_q         <= asm_d;
      ram_a_out     <= ram_a_d;
      ram_wr_out    <= ram_wr_d;
      ram_dout_out  <= ram_dout_d;
      if_done_out   <= if_done_d;
      mem_done_out  <= mem_done_d;
      if_inst_out   <= if_inst_d;
      mem_rdata_out <= mem_rdata_d;
      busy_out      <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed timing cases plus randomized traffic.
// Latency: n/a.
// Backpressure: drivers hold req until done, as the requesters do.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic        if_done_out;
  logic [31:0] if_inst_out;
  logic        mem_req_in;
  logic        mem_we_in;
  logic [1:0]  mem_len_in;
  logic [31:0] mem_addr_in;
  logic [31:0] mem_wdata_in;
  logic        mem_done_out;
  logic [31:0] mem_rdata_out;
  logic        flush_in;
  logic        busy_out;
  logic [31:0] ram_a_out;
  logic        ram_wr_out;
  logic [7:0]  ram_dout_out;
  logic [7:0]  ram_din_in;
`ifdef MEM_CTRL_IO_GUARD_EN
  logic        io_buffer_full_in;
`endif

  mem_ctrl dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .if_req_in     (if_req_in),
    .if_addr_in    (if_addr_in),
    .if_done_out   (if_done_out),
    .if_inst_out   (if_inst_out),
    .mem_req_in    (mem_req_in),
    .mem_we_in     (mem_we_in),
    .mem_len_in    (mem_len_in),
    .mem_addr_in   (mem_addr_in),
    .mem_wdata_in  (mem_wdata_in),
    .mem_done_out  (mem_done_out),
    .mem_rdata_out (mem_rdata_out),
    .flush_in      (flush_in),
    .busy_out      (busy_out),
    .ram_a_out     (ram_a_out),
    .ram_wr_out    (ram_wr_out),
    .ram_dout_out  (ram_dout_out),
    .ram_din_in    (ram_din_in)
`ifdef MEM_CTRL_IO_GUARD_EN
    ,
    .io_buffer_full_in (io_buffer_full_in)
`endif
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        ld;
    logic [31:0] d;
  } exp_t;

  exp_t        mem_q[$];
  logic [31:0] if_q[$];
  logic [7:0]  phys [logic [31:0]];   // the RAM attached to the port
  logic [7:0]  refm [logic [31:0]];   // reference view of memory contents
  logic [7:0]  pend_rd = 8'h00;
  logic        prev_if = 1'b0;
  logic        prev_mem = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] phys_rd(input logic [31:0] a);
    return phys.exists(a) ? phys[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : init_byte(a);
  endfunction

  function automatic int len_n(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  // Little-endian load of n bytes, zero-extended.
  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_rd(a + 32'(k));
    return v;
  endfunction

  function automatic void ref_store(input logic [31:0] a, input int n, input logic [31:0] wd);
    for (int k = 0; k < n; k++) refm[a + 32'(k)] = wd[8*k +: 8];
  endfunction

  // RAM: address seen in cycle C returns its byte during cycle C+1.
  initial begin
    ram_din_in = 8'h00;
    forever begin
      @(negedge clk_in);
      ram_din_in = pend_rd;
      if (ram_wr_out) phys[ram_a_out] = ram_dout_out;
      pend_rd = phys_rd(ram_a_out);
    end
  end

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk_in);
      if (if_done_out) begin
        chk("if_done_single_cycle", 32'(prev_if), 32'h0);
        if (if_q.size() == 0) begin
          total++; bad++;
          $display("FAIL if_done_unexpected: got done with inst %h, expected none", if_inst_out);
        end else begin
          chk("if_inst", if_inst_out, if_q.pop_front());
        end
      end
      if (mem_done_out) begin
        chk("mem_done_single_cycle", 32'(prev_mem), 32'h0);
        if (mem_q.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_done_unexpected: got done with rdata %h, expected none", mem_rdata_out);
        end else begin
          exp_t e;
          e = mem_q.pop_front();
          if (e.ld) chk("mem_rdata", mem_rdata_out, e.d);
        end
      end
      prev_if  = if_done_out;
      prev_mem = mem_done_out;
    end
  end

  // Issue one request and hold it until done. With tchk the RAM bus is checked
  // cycle by cycle from C1 (i = 0); exp_done_i >= 0 checks the done cycle index.
  task automatic txn(input bit is_if, input bit we, input logic [1:0] len,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input bit tchk, input int exp_done_i);
    int n;
    int done_i;
    n = is_if ? 4 : len_n(len);
    done_i = -1;
    @(negedge clk_in);
    if (is_if) begin
      if_req_in  = 1'b1;
      if_addr_in = addr;
      if_q.push_back(ref_load(addr, 4));
    end else begin
      mem_req_in   = 1'b1;
      mem_we_in    = we;
      mem_len_in   = len;
      mem_addr_in  = addr;
      mem_wdata_in = wd;
      if (we) begin
        ref_store(addr, n, wd);
        mem_q.push_back({1'b0, 32'h0});
      end else begin
        mem_q.push_back({1'b1, ref_load(addr, n)});
      end
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (tchk) begin
        if (!is_if && we) begin
          if (i < n) begin
            chk("wr_strobe", 32'(ram_wr_out), 32'h1);
            chk("wr_addr", ram_a_out, addr + 32'(i));
            chk("wr_byte", 32'(ram_dout_out), 32'(wd[8*i +: 8]));
          end else if (i == n) begin
            chk("wr_strobe_off", 32'(ram_wr_out), 32'h0);
          end
        end else if (i < n) begin
          chk("rd_addr", ram_a_out, addr + 32'(i));
          chk("rd_no_wr", 32'(ram_wr_out), 32'h0);
        end
      end
      if (is_if ? if_done_out : mem_done_out) begin
        done_i = i;
        if (is_if) if_req_in = 1'b0;
        else       mem_req_in = 1'b0;
        break;
      end
    end
    if (done_i < 0) begin
      total++; bad++;
      $display("FAIL done_timeout: no done within 200 cycles for addr %h", addr);
      if (is_if) if_req_in = 1'b0;
      else       mem_req_in = 1'b0;
    end else if (exp_done_i >= 0) begin
      chk("done_cycle", 32'(done_i), 32'(exp_done_i));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ram_a"},     ram_a_out, 32'h0);
    chk({tag, "_ram_wr"},    32'(ram_wr_out), 32'h0);
    chk({tag, "_ram_dout"},  32'(ram_dout_out), 32'h0);
    chk({tag, "_if_done"},   32'(if_done_out), 32'h0);
    chk({tag, "_mem_done"},  32'(mem_done_out), 32'h0);
    chk({tag, "_if_inst"},   if_inst_out, 32'h0);
    chk({tag, "_mem_rdata"}, mem_rdata_out, 32'h0);
    chk({tag, "_busy"},      32'(busy_out), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wd;
    rst_in = 1'b1;
    if_req_in = 1'b0; if_addr_in = 32'h0;
    mem_req_in = 1'b0; mem_we_in = 1'b0; mem_len_in = 2'd0;
    mem_addr_in = 32'h0; mem_wdata_in = 32'h0; flush_in = 1'b0;
`ifdef MEM_CTRL_IO_GUARD_EN
    io_buffer_full_in = 1'b0;
`endif
    phys[32'h1000] = 8'h13; phys[32'h1001] = 8'h05; phys[32'h1002] = 8'h00; phys[32'h1003] = 8'h00;
    refm[32'h1000] = 8'h13; refm[32'h1001] = 8'h05; refm[32'h1002] = 8'h00; refm[32'h1003] = 8'h00;
    phys[32'h2003] = 8'hFF; refm[32'h2003] = 8'hFF;

    repeat (3) @(negedge clk_in);
    chk_all_zero("reset");
    rst_in = 1'b0;

    // Word fetch: done at C6
    txn(1'b1, 1'b0, 2'd2, 32'h1000, 32'h0, 1'b1, 5);
    @(negedge clk_in);
    chk("if_inst_hold", if_inst_out, 32'h00000513);

    // Simultaneous: MEM byte load first, IF fetch begins after DONE turnaround
    fork
      txn(1'b0, 1'b0, 2'd0, 32'h2003, 32'h0, 1'b1, 2);
      txn(1'b1, 1'b0, 2'd2, 32'h1004, 32'h0, 1'b0, 9);
    join
    chk("mem_rdata_ff", mem_rdata_out, 32'h000000FF);

    // Half store then read back
    txn(1'b0, 1'b1, 2'd1, 32'h3000, 32'hAABBCCDD, 1'b1, 2);
    txn(1'b0, 1'b0, 2'd1, 32'h3000, 32'h0, 1'b1, 3);

    // Flush during the third fetch address cycle
    @(negedge clk_in);
    if_req_in = 1'b1; if_addr_in = 32'h1000;
    repeat (3) @(negedge clk_in);
    chk("flush_pre_addr", ram_a_out, 32'h1002);
    flush_in = 1'b1; if_req_in = 1'b0;
    @(negedge clk_in);
    flush_in = 1'b0;
    chk("flush_busy", 32'(busy_out), 32'h0);
    chk("flush_ram_a", ram_a_out, 32'h0);
    for (int i = 0; i < 6; i++) begin
      chk("flush_no_done", 32'(if_done_out), 32'h0);
      @(negedge clk_in);
    end
    txn(1'b1, 1'b0, 2'd2, 32'h2000, 32'h0, 1'b1, 5);

    // Flush is ignored while a MEM load is in flight
    flush_in = 1'b1;
    txn(1'b0, 1'b0, 2'd3, 32'h3000, 32'h0, 1'b1, 5);
    flush_in = 1'b0;

    // Fetch wrapping past the top of the address space
    txn(1'b1, 1'b0, 2'd2, 32'hFFFFFFFE, 32'h0, 1'b1, 5);

    // Reset during byte 1 of a word store
    wd = $urandom;
    @(negedge clk_in);
    mem_req_in = 1'b1; mem_we_in = 1'b1; mem_len_in = 2'd2;
    mem_addr_in = 32'h3010; mem_wdata_in = wd;
    @(negedge clk_in);
    @(negedge clk_in);
    chk("rst_mid_wr", 32'(ram_wr_out), 32'h1);
    chk("rst_mid_addr", ram_a_out, 32'h3011);
    ref_store(32'h3010, 2, wd);   // bytes 0 and 1 reached the RAM
    rst_in = 1'b1; mem_req_in = 1'b0;
    @(negedge clk_in);
    chk_all_zero("rst_mid");
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);

`ifdef MEM_CTRL_IO_GUARD_EN
    // IO store held off while the IO buffer reports full
    wd = $urandom;
    @(negedge clk_in);
    io_buffer_full_in = 1'b1;
    mem_req_in = 1'b1; mem_we_in = 1'b1; mem_len_in = 2'd0;
    mem_addr_in = 32'h30000; mem_wdata_in = wd;
    ref_store(32'h30000, 1, wd);
    mem_q.push_back({1'b0, 32'h0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      chk("io_blocked_wr", 32'(ram_wr_out), 32'h0);
    end
    io_buffer_full_in = 1'b0;
    @(negedge clk_in);
    chk("io_issue_wr", 32'(ram_wr_out), 32'h1);
    chk("io_issue_addr", ram_a_out, 32'h30000);
    chk("io_issue_byte", 32'(ram_dout_out), 32'(wd[7:0]));
    @(negedge clk_in);
    chk("io_done", 32'(mem_done_out), 32'h1);
    mem_req_in = 1'b0;
`endif

    // Randomized concurrent traffic
    fork
      begin
        for (int t = 0; t < 30; t++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk_in);
          txn(1'b1, 1'b0, 2'd2, 32'h1000 + 32'($urandom_range(0, 255)), 32'h0, 1'b0, -1);
        end
      end
      begin
        for (int t = 0; t < 50; t++) begin
          logic        rwe;
          logic [1:0]  rlen;
          logic [31:0] raddr;
          repeat ($urandom_range(0, 3)) @(negedge clk_in);
          rwe  = 1'($urandom_range(0, 1));
          rlen = 2'($urandom_range(0, 3));
          if (rwe || $urandom_range(0, 1) == 1) raddr = 32'h3000 + 32'($urandom_range(0, 250));
          else                                  raddr = 32'h1000 + 32'($urandom_range(0, 250));
          txn(1'b0, rwe, rlen, raddr, $urandom, 1'b0, -1);
        end
      end
    join

    repeat (5) @(negedge clk_in);
    chk("if_queue_drained", 32'(if_q.size()), 32'h0);
    chk("mem_queue_drained", 32'(mem_q.size()), 32'h0);
    for (int k = 0; k < 260; k++) begin
      logic [31:0] a;
      a = 32'h3000 + 32'(k);
      chk("ram_contents", 32'(phys_rd(a)), 32'(ref_rd(a)));
    end
    chk("ram_contents_io", 32'(phys_rd(32'h30000)), 32'(ref_rd(32'h30000)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Owns the single byte-wide RAM port.
- Arbitrates between two requesters: instruction fetch (IF, always 4-byte reads) and the MEM stage (byte/half/word loads and stores).
- Sequences each request as consecutive byte transfers, assembles or splits 32-bit words little-endian, and reports completion with a one-cycle done pulse.
- Sits between the if/mem pipeline stages and the top-level RAM interface; the pipeline stall controller keys off its busy/done signals.

Parameters:
- ADDR_WIDTH, 32, width of all byte addresses.
- IO_ADDR_HI, 2'b11, value of addr[17:16] that marks the IO region (used only by the optional feature).

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- if_req_in  in  1  IF fetch request; held high until if_done_out.
- if_addr_in  in  ADDR_WIDTH  fetch address.
- if_done_out  out  1  one-cycle pulse; if_inst_out valid in the same cycle.
- if_inst_out  out  32  fetched instruction.
- mem_req_in  in  1  MEM request; held high until mem_done_out.
- mem_we_in  in  1  1 = store, 0 = load.
- mem_len_in  in  2  0 = byte, 1 = half, 2 = word (3 is treated as word).
- mem_addr_in  in  ADDR_WIDTH  access address.
- mem_wdata_in  in  32  store data; low bytes are used.
- mem_done_out  out  1  one-cycle pulse.
- mem_rdata_out  out  32  load data, zero-extended; mem stage applies sign extension.
- flush_in  in  1  branch mispredict; aborts an in-flight fetch.
- busy_out  out  1  high whenever state != IDLE.
- ram_a_out  out  ADDR_WIDTH  RAM byte address.
- ram_wr_out  out  1  RAM write strobe.
- ram_dout_out  out  8  RAM write byte.
- ram_din_in  in  8  RAM read byte; valid one cycle after its address is presented.

Behaviour:
- Clocking and reset: single clock clk_in; reset rst_in is synchronous and active-high. All outputs are registered.
- Reset values: every output is 0, state = IDLE, byte counter = 0, assembly register = 0.
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- Arbitration in IDLE:
  - mem_req_in beats if_req_in when both are high.
  - if_req_in together with flush_in in the same cycle is not accepted.
  - A granted transaction is never preempted, except that flush aborts IF_RD.
- Length: n = 4 for IF; n = 1/2/4 for MEM per mem_len_in.
- Read sequence:
  - On accept, ram_a_out = addr in cycle C1, addr+1 in C2, up to addr+n-1.
  - Byte k is captured from ram_din_in in cycle C1+k+1 into bits [8k+7:8k].
  - done and data are asserted in cycle C1+n+1.
  - Word read total: accept edge to done = 6 cycles.
- Write sequence:
  - In cycle C1+k: ram_wr_out = 1, ram_a_out = addr+k, ram_dout_out = wdata[8k+7:8k], for k = 0..n-1.
  - mem_done_out is asserted in cycle C1+n; ram_wr_out = 0 in that cycle.
- DONE state:
  - Lasts exactly 1 cycle; asserts the relevant done output.
  - No request is accepted during DONE (one-cycle turnaround so the requester can drop req); then return to IDLE.
  - if_inst_out and mem_rdata_out hold their value until the next completion of the same requester.
- Outside active transfers: ram_wr_out = 0, ram_a_out = 0.
- Address arithmetic: addr+k wraps modulo 2^ADDR_WIDTH.
- Flush:
  - flush_in high in any IF_RD cycle → IDLE at the next edge, no if_done_out, counter cleared. A new request may be accepted in the following cycle.
  - flush_in is ignored during MEM_RD, MEM_WR and DONE.
- Reset mid-transaction: state → IDLE at the edge; ram_wr_out drops that edge; no done pulse is produced.

Optional Feature:
- Macro: MEM_CTRL_IO_GUARD_EN.
- Defined:
  - Adds input io_buffer_full_in (1 bit).
  - In MEM_WR, a byte whose address has addr[17:16] == IO_ADDR_HI is not issued while io_buffer_full_in is high: ram_wr_out = 0 and the counter holds.
  - Issue resumes the cycle after full drops; completion timing shifts accordingly.
- Undefined: the port is absent and no write gating occurs.

Decomposition:
- Shared package (defines.v) holds:
  - state encodings MC_IDLE/MC_IF_RD/MC_MEM_RD/MC_MEM_WR/MC_DONE;
  - length codes LenByte/LenHalf/LenWord;
  - IO_ADDR_HI;
  - existing True_v/False_v style constants.
- One sub-module, mem_byte_pack: combinational; byte index plus 32-bit word ↔ byte lane select/insert. It is shared by the read assembly and write split paths.

Test Plan:
- IF word fetch: if_req = 1, addr = 0x1000, RAM holds 13 05 00 00 → ram_a 0x1000..0x1003 on consecutive cycles; if_done_out pulses 6 cycles after accept; if_inst_out = 0x00000513.
- Simultaneous requests: if_req and mem_req (load byte, 0x2003 = 0xFF) in the same cycle → MEM served first, mem_rdata_out = 0x000000FF after 2+1 cycles; IF starts after DONE; no RAM cycle overlap.
- Half store: mem_we = 1, len = 1, addr = 0x3000, wdata = 0xAABBCCDD → ram_wr high 2 cycles, (0x3000, 0xDD) then (0x3001, 0xCC); mem_done 1 cycle later; 0xAA/0xBB never written.
- Flush mid-fetch: flush_in asserted during the 3rd IF address cycle → no if_done_out; state IDLE next cycle; a new if_req at 0x2000 returns the correct word.
- Reset mid-store: rst_in asserted during word-store byte 1 → ram_wr_out 0 after the edge; no mem_done_out; all outputs 0.
- MEM_CTRL_IO_GUARD_EN: store byte to 0x30000 with io_buffer_full_in high for 5 cycles → no ram_wr during those cycles; write issued the cycle after full drops; done follows.
